// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_HALT_WORD = 32'h0000_0000;
   localparam logic [31:0] INST_BYTES    = 32'd4;

   // Queue entry layout: instruction word in the upper half, its PC below.
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus and decode handshake between the fetch sequencer and its neighbours.
interface fetch_sequencer_if;

   logic [31:0] readAddress;
   logic [31:0] instruction;
   logic        fimDoArquivo;
   logic        instValid;
   logic [31:0] instData;
   logic [31:0] instPc;
   logic        instReady;

   modport master (
      output readAddress, instValid, instData, instPc,
      input  instruction, fimDoArquivo, instReady
   );

   modport slave (
      input  readAddress, instValid, instData, instPc,
      output instruction, fimDoArquivo, instReady
   );

endinterface

// File: rtl/fetch_queue.sv
// In-order circular instruction queue with flush; head reads as zero when empty.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        enq,
   input  logic [63:0] enqData,
   input  logic        deq,
   output logic        full,
   output logic        empty,
   output logic [63:0] headData
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

   logic [63:0]    mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_enq, do_deq;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign headData = empty ? 64'h0 : mem_q[rd_ptr_q];

   // A dequeue frees the slot in the same cycle, so a full queue may still accept.
   assign do_deq = deq && !empty && !flush;
   assign do_enq = enq && !flush && (!full || do_deq);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({do_enq, do_deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; entries are only visible through count/pointers, which are reset.
   always_ff @(posedge clk) begin
      if (do_enq) mem_q[wr_ptr_q] <= enqData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, fetch FSM and fetch counter; feeds decode through fetch_queue.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter int          PTR_W    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   fetch_sequencer_if.master   bus,
   input  logic                redirectValid,
   input  logic [31:0]         redirectTarget,
   output logic                halted,
   output logic                errMisaligned,
   output logic [31:0]         fetchCount
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fetch_count_q, fetch_count_d;
   logic         err_q, err_d;

   logic         q_flush, q_enq, q_deq, q_full, q_empty;
   logic [63:0]  q_head_data;
   fetch_entry_t head, enq_entry;
   logic         target_aligned, end_of_program, space;

   fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (q_flush),
      .enq      (q_enq),
      .enqData  (enq_entry),
      .deq      (q_deq),
      .full     (q_full),
      .empty    (q_empty),
      .headData (q_head_data)
   );

   assign head             = q_head_data;
   assign enq_entry        = '{data: bus.instruction, pc: pc_q};
   assign bus.readAddress  = pc_q;
   assign bus.instValid    = !q_empty;
   assign bus.instData     = head.data;
   assign bus.instPc       = head.pc;
   assign halted           = (state_q == HALT) && q_empty;
   assign errMisaligned    = err_q;
   assign fetchCount       = fetch_count_q;

   assign q_deq          = bus.instValid && bus.instReady;
   assign target_aligned = (redirectTarget[1:0] == 2'b00);
   assign end_of_program = bus.fimDoArquivo || (bus.instruction == NOP_HALT_WORD);
   assign space          = !q_full || q_deq;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_count_d = fetch_count_q;
      err_d         = err_q;
      q_flush       = 1'b0;
      q_enq         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = RUN;
               pc_d          = RESET_PC;
               fetch_count_d = '0;
               q_flush       = 1'b1;
            end
         end
         RUN: begin
            if (redirectValid) begin
               q_flush = 1'b1;
               if (target_aligned) begin
                  pc_d = redirectTarget;
               end else begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end
            end else if (end_of_program) begin
               state_d = HALT;
            end else if (space) begin
               q_enq         = 1'b1;
               pc_d          = pc_q + INST_BYTES;
               fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                                : fetch_count_q + 32'd1;
            end
         end
         HALT: begin
            // A misaligned redirect here only flags the error; queued words keep draining.
            if (redirectValid) begin
               if (target_aligned) begin
                  q_flush = 1'b1;
                  pc_d    = redirectTarget;
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end else if (start) begin
               state_d       = RUN;
               pc_d          = RESET_PC;
               fetch_count_d = '0;
               q_flush       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         fetch_count_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
         err_q         <= err_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by randomized traffic.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam int          M_IDLE = 0, M_RUN = 1, M_HALT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        redirectValid = 1'b0;
   logic [31:0] redirectTarget = 32'h0;
   logic        halted, errMisaligned;
   logic [31:0] fetchCount;

   fetch_sequencer_if bus();

   fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .bus            (bus),
      .redirectValid  (redirectValid),
      .redirectTarget (redirectTarget),
      .halted         (halted),
      .errMisaligned  (errMisaligned),
      .fetchCount     (fetchCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic [31:0] imem [64];
   logic [31:0] fim_addr = 32'hFFFF_FFFF;

   // Reference model: fetch status plus the words decode should still receive, in order.
   int          m_state = M_IDLE;
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_cnt = 32'h0;
   logic        m_err = 1'b0;
   logic        m_flush = 1'b0;
   exp_t        exp_q[$];

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd256) return imem[a[7:2]];
      return 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fill_mem(input int first, input int last);
      for (int i = 0; i < 64; i++)
         imem[i] = (i >= first && i <= last) ? 32'h0010_0013 + 32'(i << 7) : 32'h0;
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_pc    = RESET_PC;
      m_cnt   = 32'h0;
      m_err   = 1'b0;
      m_flush = 1'b0;
      exp_q.delete();
   endtask

   // One clock cycle: drive inputs, check status against the model, then advance the model.
   task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt, input logic st);
      logic [31:0] w;
      logic        fim, deq, aligned;
      @(negedge clk);
      bus.instReady     = rdy;
      redirectValid     = rv;
      redirectTarget    = tgt;
      start             = st;
      bus.instruction   = mem_word(bus.readAddress);
      bus.fimDoArquivo  = (bus.readAddress == fim_addr);
      #1;
      check("read_address", bus.readAddress, m_pc);
      check("inst_valid", 32'(bus.instValid), 32'(exp_q.size() != 0));
      check("halted", 32'(halted), 32'(m_state == M_HALT && exp_q.size() == 0));
      check("fetch_count", fetchCount, m_cnt);
      check("err_misaligned", 32'(errMisaligned), 32'(m_err));
      if (exp_q.size() == 0) begin
         check("empty_data", bus.instData, 32'h0);
         check("empty_pc", bus.instPc, 32'h0);
      end
      w       = mem_word(m_pc);
      fim     = (m_pc == fim_addr);
      deq     = (exp_q.size() != 0) && rdy;
      aligned = ((tgt & 32'd3) == 32'd0);
      m_flush = 1'b0;
      if (m_state == M_IDLE) begin
         if (st) begin
            m_state = M_RUN; m_pc = RESET_PC; m_cnt = 32'h0; m_flush = 1'b1;
         end
      end else if (m_state == M_RUN) begin
         if (rv) begin
            m_flush = 1'b1;
            if (aligned) m_pc = tgt;
            else begin m_err = 1'b1; m_state = M_HALT; end
         end else if (fim || w == 32'h0) begin
            m_state = M_HALT;
         end else if (exp_q.size() < DEPTH || deq) begin
            exp_q.push_back('{pc: m_pc, data: w});
            m_pc = m_pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
         end
      end else begin
         if (rv) begin
            if (aligned) begin m_flush = 1'b1; m_pc = tgt; m_state = M_RUN; end
            else m_err = 1'b1;
         end else if (st) begin
            m_state = M_RUN; m_pc = RESET_PC; m_cnt = 32'h0; m_flush = 1'b1;
         end
      end
      if (m_flush) exp_q.delete();
   endtask

   // Monitor: every accepted head must be the oldest expected word.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.instValid && bus.instReady && !m_flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_transfer actual_pc=%h expected=none at %0t", bus.instPc, $time);
            end else begin
               e = exp_q.pop_front();
               check("head_pc", bus.instPc, e.pc);
               check("head_data", bus.instData, e.data);
            end
         end
      end
   end

   initial begin
      bus.instReady    = 1'b0;
      bus.instruction  = 32'h0;
      bus.fimDoArquivo = 1'b0;
      fill_mem(0, -1);
      model_reset();

      // Reset values
      #3;
      check("rst_valid", 32'(bus.instValid), 32'h0);
      check("rst_data", bus.instData, 32'h0);
      check("rst_pc", bus.instPc, 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_err", 32'(errMisaligned), 32'h0);
      check("rst_count", fetchCount, 32'h0);
      check("rst_addr", bus.readAddress, RESET_PC);
      @(negedge clk);
      rst_n = 1'b1;

      // Straight-line program
      fill_mem(0, -1);
      imem[0] = 32'h0050_0093; imem[1] = 32'h0010_0113; imem[2] = 32'h0020_81B3;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0);
         check("line_pc", bus.instPc, 32'(i * 4));
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
      check("line_halted", 32'(halted), 32'h1);
      check("line_count", fetchCount, 32'd3);

      // Backpressure
      fill_mem(0, 7);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
      check("bp_addr", bus.readAddress, 32'h8);
      check("bp_head", bus.instPc, 32'h0);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

      // Redirect flushes queued PC 4 and 8
      fill_mem(0, 7);
      for (int i = 16; i < 20; i++) imem[i] = 32'h00A0_0513 + 32'(i);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h40, 1'b0);
      check("redir_head_before", bus.instPc, 32'h4);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("redir_valid_gap", 32'(bus.instValid), 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("redir_target_head", bus.instPc, 32'h40);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

      // End of program at 0x10 while draining, then recover via redirect
      fill_mem(0, 7);
      fim_addr = 32'h10;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("hr_halted", 32'(halted), 32'h1);
      step(1'b1, 1'b1, 32'h0C, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("hr_halted_drop", 32'(halted), 32'h0);
      check("hr_addr", bus.readAddress, 32'h0C);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("hr_head", bus.instPc, 32'h0C);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
      fim_addr = 32'hFFFF_FFFF;

      // Misaligned redirect
      fill_mem(0, 7);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 32'h42, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("mis_err", 32'(errMisaligned), 32'h1);
      check("mis_halted", 32'(halted), 32'h1);
      check("mis_addr", bus.readAddress, 32'h8);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
      check("mis_err_sticky", 32'(errMisaligned), 32'h1);

      // Asynchronous reset with a full queue
      step(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
      check("ar_full", 32'(bus.instValid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(bus.instValid), 32'h0);
      check("ar_halted", 32'(halted), 32'h0);
      check("ar_addr", bus.readAddress, RESET_PC);
      check("ar_count", fetchCount, 32'h0);
      check("ar_err", 32'(errMisaligned), 32'h0);
      model_reset();
      bus.instReady = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 64; i++)
         imem[i] = ($urandom_range(0, 19) == 0) ? 32'h0 : ($urandom | 32'h1);
      fim_addr = {24'h0, 6'($urandom_range(8, 63)), 2'b00};
      for (int n = 0; n < 600; n++) begin
         logic        rv;
         logic [31:0] tgt;
         rv  = ($urandom_range(0, 14) == 0);
         tgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         step(1'($urandom_range(0, 3) != 0), rv, tgt, 1'($urandom_range(0, 9) == 0));
      end

      #3;
      bus.instReady = 1'b0;
      redirectValid = 1'b0;
      start = 1'b0;
      @(negedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
